// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, fetch FSM states
// and the queue entry carried from fetch to IF/ID.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO; head is always entry 0.
// Flush wins over push and pop.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  fq_entry_t  din_i,
    output logic [1:0] count_o,
    output fq_entry_t  head_o
);

    fq_entry_t  ent_q [2];
    logic [1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    ent_q[cnt_q[0]] <= din_i;
                    cnt_q           <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent_q[0] <= ent_q[1];
                    cnt_q    <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        ent_q[0] <= ent_q[1];
                        ent_q[1] <= din_i;
                    end else begin
                        ent_q[0] <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests only launch with room reserved for their response.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && cnt_q == 2'd2));

    assign count_o = cnt_q;
    assign head_o  = ent_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory
// request at a time and buffers responses for IF/ID.
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               IF_ID_Write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
);

    import cpu_pkg::*;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;

    logic [1:0] count;
    logic [1:0] count_nxt;
    fq_entry_t  head;
    fq_entry_t  din;
    logic       ack_ok;
    logic       push;
    logic       pop;
    logic       busy_nxt;
    logic       start;

    assign ack_ok    = req_q && imem_ack;
    assign push      = ack_ok && (state_q == FETCH) && !branch_taken;
    assign pop       = IF_ID_Write && instr_valid;
    assign count_nxt = count + 2'(push) - 2'(pop);
    assign busy_nxt  = req_q && !imem_ack;
    assign start     = (state_q == FETCH) && !busy_nxt && pc_write
                    && (count_nxt < 2'd2) && !branch_taken;

    assign din = '{pc: addr_q, instr: imem_rdata};

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_taken),
        .din_i   (din),
        .count_o (count),
        .head_o  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (branch_taken) begin
                        fetch_pc_q <= branch_target;
                        // A live request must still be drained.
                        if (busy_nxt) state_q <= DISCARD;
                        else          req_q   <= 1'b0;
                    end else if (start) begin
                        req_q      <= 1'b1;
                        addr_q     <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
                    end else if (ack_ok) begin
                        req_q <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (branch_taken) fetch_pc_q <= branch_target;
                    if (ack_ok) begin
                        req_q   <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count != 2'd0) && !branch_taken;
    assign instr_out   = head.instr;
    assign pc_out      = head.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID latch and the hazard detection unit. It owns the program counter and issues one-at-a-time requests to instruction memory, which may have variable latency. Returned instructions are buffered in a 2-entry queue and presented to IF/ID. It honours `pc_write` and `IF_ID_Write` from the hazard unit and redirects on taken branches.

## Interface
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 0: PC value after reset.
---
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc_write`  in  1  from hazard unit; 0 = freeze PC, start no new request.
- `IF_ID_Write`  in  1  from hazard unit; 1 = IF/ID consumes the queue head this cycle.
- `branch_taken`  in  1  redirect strobe, one cycle.
- `branch_target`  in  ADDR_W  redirect address, valid with `branch_taken`.
- `imem_req`  out  1  registered request to instruction memory.
- `imem_addr`  out  ADDR_W  registered request address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory response; data valid this cycle; may arrive in any cycle with `imem_req`=1.
- `imem_rdata`  in  INSTR_W  instruction word.
- `instr_valid`  out  1  queue head valid.
- `instr_out`  out  INSTR_W  queue-head instruction.
- `pc_out`  out  ADDR_W  address of queue-head instruction.

## Operation
- **State:** `fetch_pc`, a 2-entry queue of {pc, instr}, the request register, and an FSM with states `FETCH` and `DISCARD`.
- **Outstanding request:** `imem_req`=1 and `imem_ack`=0.
- **New request (FETCH):** starts when all hold:
  - no request is outstanding after this cycle;
  - `pc_write`=1;
  - queue count after this cycle's push/pop < 2;
  - `branch_taken`=0.
  - Effect: next cycle `imem_req`=1, `imem_addr`=`fetch_pc`, and `fetch_pc` ← `fetch_pc`+1.
- **PC arithmetic:** `fetch_pc`+1 is modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- **Ack in FETCH:**
  - Push {`imem_addr`, `imem_rdata`} into the queue.
  - `imem_req` drops unless a new request starts in the same cycle; back-to-back requests are allowed.
- **Pop:** when `IF_ID_Write`=1, `instr_valid`=1 and `branch_taken`=0. A push and a pop may occur in the same cycle.
- **`pc_write`=0:** freezes `fetch_pc` and blocks new requests. An outstanding request still completes and is enqueued.
- **Redirect (`branch_taken`=1), which overrides `pc_write`=0:**
  - Queue flushed; no pop that cycle.
  - `fetch_pc` ← `branch_target`.
  - An ack arriving in the redirect cycle is dropped.
  - If a request remains outstanding, go to `DISCARD`: hold `imem_req` and `imem_addr` until ack, drop that data, then return to `FETCH`.
- **Redirect while in DISCARD:** updates `fetch_pc` only.
- **Queue overflow:** cannot occur; a request starts only with space reserved for its response. An ack into a full queue is an assertion failure.

## Timing
- **Reset values:**
  - `imem_req`=0, `imem_addr`=0.
  - `instr_valid`=0, `instr_out`=0, `pc_out`=0.
  - `fetch_pc`=RESET_PC, queue empty, FSM=`FETCH`.
- **Reset mid-request:** the request is abandoned immediately; the bench must not ack after reset.
- **First request:** `imem_req`=1 at `imem_addr`=RESET_PC in the first cycle after `rst_n` deasserts, subject to the new-request conditions.
- **Ack to output:** `imem_ack` at edge N gives `instr_valid`=1 after edge N; the queue is registered.
- **`instr_valid`:** forced to 0 in any cycle with `branch_taken`=1.
- **Redirect with nothing outstanding:** `imem_req`=1 at `branch_target` one cycle after `branch_taken`.
- **Redirect with a request outstanding:** the target request starts in the cycle after the discard ack.
- **Throughput:** one instruction per cycle when the memory acks in the request cycle and `IF_ID_Write`=1.

## Structure
- **Shared package `cpu_pkg`:**
  - `ADDR_W` and `INSTR_W` defaults;
  - fetch FSM state typedef (`FETCH`, `DISCARD`);
  - queue-entry struct {pc, instr}.
- **Sub-module `fetch_queue`:** 2-entry FIFO.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.

## Test plan
- **Reset:** reset, release, zero-latency ack with rdata=0xA000+addr → `instr_out` 0xA000, 0xA001, 0xA002 on consecutive cycles; `pc_out` 0,1,2.
- **IF/ID back-pressure:** hold `IF_ID_Write`=0 → exactly 2 instructions queued, `imem_req` stays 0. Release → pops 0, then 1, then a request at addr 2.
- **PC freeze:** `pc_write`=0 while a 3-cycle-latency request at addr 5 is outstanding → the addr-5 instruction is enqueued, no further request, `fetch_pc` stays 6.
- **Redirect during outstanding request:** `branch_taken`, target 0x40, during an outstanding request at 7 with ack 2 cycles later → data for addr 7 is dropped, the next request is addr 0x40, and no stale `instr_valid` appears.
- **Redirect with simultaneous ack:** redirect to 0x10 in the same cycle as the ack for addr 3 → data for addr 3 is dropped, queue is empty, the next cycle requests 0x10.
- **Wrap and mid-request reset:**
  - With RESET_PC=0xFFFF → requests go to 0xFFFF then 0x0000.
  - Assert `rst_n`=0 mid-request → all outputs return to reset values asynchronously.
